// File: rtl/rename_stage_pkg.sv
// Shared types and constants for the rename stage and its map table.
package rename_stage_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_W    = 7;
    localparam int FL_DEPTH  = 96;

    typedef logic [PHYS_W-1:0] preg_t;
    typedef preg_t map_t [ARCH_REGS];

    typedef struct packed {
        preg_t       ps1;
        preg_t       ps2;
        preg_t       pd;
        preg_t       pd_old;
        logic        has_rd;
        logic        is_branch;
        logic [31:0] pc;
    } rn_out_t;

    // Free list depth is not a power of two, so the wrap is explicit.
    function automatic preg_t ptr_add(input preg_t p, input logic inc);
        if (!inc) return p;
        return (p == preg_t'(FL_DEPTH - 1)) ? '0 : p + preg_t'(1);
    endfunction
endpackage

// File: rtl/rename_map_table.sv
// Architectural-to-physical map with one branch checkpoint copy.
module rename_map_table
    import rename_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       we_i,
    input  preg_t      wdata_i,
    input  logic       save_i,
    input  logic       restore_i,
    output preg_t      ps1_o,
    output preg_t      ps2_o,
    output preg_t      pd_old_o
);
    map_t map_q, map_d;
    map_t ckpt_q, ckpt_d;

    assign ps1_o    = map_q[rs1_i];
    assign ps2_o    = map_q[rs2_i];
    assign pd_old_o = map_q[rd_i];

    // The checkpoint captures the map after this instruction's own write.
    always_comb begin
        map_d = map_q;
        if (restore_i) begin
            map_d = ckpt_q;
        end else if (we_i) begin
            map_d[rd_i] = wdata_i;
        end
        ckpt_d = save_i ? map_d : ckpt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i]  <= preg_t'(i);
                ckpt_q[i] <= preg_t'(i);
            end
        end else begin
            map_q  <= map_d;
            ckpt_q <= ckpt_d;
        end
    end
endmodule

// File: rtl/rename_stage.sv
// Single-issue rename stage: map lookup, free list pop, one branch checkpoint.
module rename_stage
    import rename_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_has_rd,
    input  logic              in_is_branch,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PHYS_W-1:0] out_ps1,
    output logic [PHYS_W-1:0] out_ps2,
    output logic [PHYS_W-1:0] out_pd,
    output logic [PHYS_W-1:0] out_pd_old,
    output logic              out_has_rd,
    output logic              out_is_branch,
    output logic [31:0]       out_pc,
    output logic              fl_read_en,
    input  logic [PHYS_W-1:0] fl_pd_new,
    input  logic              fl_empty,
    input  logic [PHYS_W-1:0] fl_r_ptr,
    input  logic [PHYS_W-1:0] fl_w_ptr,
    input  logic [PHYS_W-1:0] fl_list [0:FL_DEPTH-1],
    output logic              fl_mispredict,
    output logic [PHYS_W-1:0] fl_re_r_ptr,
    output logic [PHYS_W-1:0] fl_re_w_ptr,
    output logic [PHYS_W-1:0] fl_re_list [0:FL_DEPTH-1],
    input  logic              branch_resolved,
    input  logic              mispredict,
    output logic              ckpt_valid
);
    rn_out_t out_q, out_d;
    logic    out_valid_q, out_valid_d;
    logic    ckpt_valid_q, ckpt_valid_d;
    preg_t   ckpt_r_ptr_q, ckpt_r_ptr_d;
    logic    alloc, accept, mis_take;
    preg_t   map_ps1, map_ps2, map_pd_old;

    assign alloc    = in_has_rd && (in_rd != 5'd0);
    assign mis_take = !reset && mispredict && ckpt_valid_q;
    assign in_ready = !reset && !mispredict && (!out_valid_q || out_ready)
                      && !(alloc && fl_empty)
                      && !(in_is_branch && ckpt_valid_q && !branch_resolved);
    assign accept     = in_valid && in_ready;
    assign fl_read_en = accept && alloc;

    rename_map_table u_map (
        .clk       (clk),
        .reset     (reset),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .rd_i      (in_rd),
        .we_i      (fl_read_en),
        .wdata_i   (fl_pd_new),
        .save_i    (accept && in_is_branch),
        .restore_i (mis_take),
        .ps1_o     (map_ps1),
        .ps2_o     (map_ps2),
        .pd_old_o  (map_pd_old)
    );

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        ckpt_valid_d = ckpt_valid_q;
        ckpt_r_ptr_d = ckpt_r_ptr_q;
        if (mis_take) begin
            out_valid_d  = 1'b0;
            ckpt_valid_d = 1'b0;
        end else begin
            if (accept) begin
                out_d.ps1       = map_ps1;
                out_d.ps2       = map_ps2;
                out_d.pd        = alloc ? fl_pd_new : '0;
                out_d.pd_old    = alloc ? map_pd_old : '0;
                out_d.has_rd    = in_has_rd;
                out_d.is_branch = in_is_branch;
                out_d.pc        = in_pc;
                out_valid_d     = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            // A new branch in the resolve cycle takes over the checkpoint.
            if (accept && in_is_branch) begin
                ckpt_valid_d = 1'b1;
                ckpt_r_ptr_d = ptr_add(fl_r_ptr, alloc);
            end else if (branch_resolved) begin
                ckpt_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            ckpt_valid_q <= 1'b0;
            ckpt_r_ptr_q <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            ckpt_valid_q <= ckpt_valid_d;
            ckpt_r_ptr_q <= ckpt_r_ptr_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_ps1       = out_q.ps1;
    assign out_ps2       = out_q.ps2;
    assign out_pd        = out_q.pd;
    assign out_pd_old    = out_q.pd_old;
    assign out_has_rd    = out_q.has_rd;
    assign out_is_branch = out_q.is_branch;
    assign out_pc        = out_q.pc;
    assign ckpt_valid    = ckpt_valid_q;

    // Restore keeps the live write side so frees from older commits survive.
    assign fl_mispredict = mis_take;
    assign fl_re_r_ptr   = ckpt_r_ptr_q;
    assign fl_re_w_ptr   = fl_w_ptr;
    assign fl_re_list    = fl_list;
endmodule
